// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN memory path: arbiter states, requester ids
// and default bus widths.
package cnn_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_DONE  = 2'd2
    } arbState_t;

    localparam int REQ_LOAD = 0;
    localparam int REQ_CONV = 1;
    localparam int REQ_POOL = 2;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;
    localparam int DEF_LW = 16;

endpackage

// File: rtl/cnn_mem_arbiter_rr_picker.sv
// Combinational round-robin select: first requester at or after ptr wins.
module rr_picker
    import cnn_pkg::*;
#(
    parameter int NREQ = REQ_POOL + 1,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic            valid
);

    function automatic logic [PW-1:0] slot(input logic [PW-1:0] start, input int offset);
        int s;
        s = int'(start) + offset;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    always_comb begin
        // NOTE: defaults first so every path drives win/valid; otherwise a latch is inferred.
        win   = '0;
        valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && req[slot(ptr, i)]) begin
                win[slot(ptr, i)] = 1'b1;
                valid             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cnn_mem_arbiter.sv
// Round-robin arbiter and burst sequencer sharing the single-port CNN memory
// between the load path and the conv/pool write-back paths.
module cnn_mem_arbiter
    import cnn_pkg::*;
#(
    parameter int NREQ = REQ_POOL + 1,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW,
    parameter int LW   = DEF_LW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*LW-1:0] len,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  beat,
    output logic [NREQ-1:0]  rvalid,
    output logic [NREQ-1:0]  done,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arbState_t       state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   own;
    logic [PW-1:0]   winIdx;
    logic [NREQ-1:0] win;
    logic            winValid;
    logic [AW-1:0]   base;
    logic [LW-1:0]   burstLen;
    logic [LW-1:0]   cnt;

    logic [AW-1:0] addrArr  [NREQ];
    logic [LW-1:0] lenArr   [NREQ];
    logic [DW-1:0] wdataArr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : gUnpack
        assign addrArr[g]  = addr[g*AW +: AW];
        assign lenArr[g]   = len[g*LW +: LW];
        assign wdataArr[g] = wdata[g*DW +: DW];
    end

    rr_picker #(.NREQ(NREQ), .PW(PW)) uPicker (
        .req   (req),
        .ptr   (ptr),
        .win   (win),
        .valid (winValid)
    );

    function automatic logic [PW-1:0] wrapInc(input logic [PW-1:0] idx);
        return (int'(idx) >= NREQ - 1) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        winIdx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) winIdx = PW'(i);
        end
    end

    // Write data is the only unregistered output: it follows the granted requester.
    always_comb begin
        mem_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) mem_wdata = wdataArr[i];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ARB_IDLE;
            ptr      <= '0;
            own      <= '0;
            cnt      <= '0;
            base     <= '0;
            burstLen <= '0;
            gnt      <= '0;
            beat     <= '0;
            rvalid   <= '0;
            done     <= '0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
        end else begin
            rvalid <= beat & ~{NREQ{mem_we}};
            done   <= '0;
            case (state)
                ARB_IDLE: begin
                    if (winValid) begin
                        own      <= winIdx;
                        base     <= addrArr[winIdx];
                        burstLen <= lenArr[winIdx];
                        cnt      <= '0;
                        if (lenArr[winIdx] == '0) begin
                            state <= ARB_DONE;
                            done  <= win;
                            ptr   <= wrapInc(winIdx);
                        end else begin
                            state    <= ARB_BURST;
                            gnt      <= win;
                            beat     <= win;
                            mem_we   <= we[winIdx];
                            mem_addr <= addrArr[winIdx];
                        end
                    end
                end
                ARB_BURST: begin
                    if (cnt == burstLen - 1'b1) begin
                        state    <= ARB_DONE;
                        done     <= gnt;
                        gnt      <= '0;
                        beat     <= '0;
                        mem_we   <= 1'b0;
                        mem_addr <= '0;
                        ptr      <= wrapInc(own);
                    end else begin
                        cnt      <= cnt + 1'b1;
                        mem_addr <= base + AW'(cnt) + AW'(1);
                    end
                end
                ARB_DONE: state <= ARB_IDLE;
                default:  state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_mem_arbiter.sv
// Scoreboard bench for cnn_mem_arbiter: stimulus pushes per-cycle expected
// events, a negedge monitor pops and compares whatever the DUT presents.
module tb_cnn_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [47:0] addr;
    logic [47:0] len;
    logic [47:0] wdata;
    logic [2:0]  gnt;
    logic [2:0]  beat;
    logic [2:0]  rvalid;
    logic [2:0]  done;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;

    cnn_mem_arbiter #(.NREQ(3), .AW(16), .DW(16), .LW(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .len       (len),
        .wdata     (wdata),
        .gnt       (gnt),
        .beat      (beat),
        .rvalid    (rvalid),
        .done      (done),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [2:0]  gnt;
        logic [2:0]  beat;
        logic [2:0]  rvalid;
        logic [2:0]  done;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } expEvent_t;

    expEvent_t    expQ[$];
    int           cyc = 0;
    int           nChecks = 0;
    int           nPass = 0;
    int           expCnt [3] = '{0, 0, 0};
    logic [15:0]  wordCnt [3] = '{16'd0, 16'd0, 16'd0};
    logic [2:0]   beatSeen = 3'b000;
    logic [15:0]  mem [int];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s @cyc %0d: got %h, required %h", name, cyc, act, exp);
    endtask

    function automatic logic [15:0] wordBase(input int r);
        case (r)
            0:       return 16'h1000;
            1:       return 16'h2000;
            default: return 16'd7;
        endcase
    endfunction

    // Requester model: each requester presents its next word once a beat of it has ended.
    always @(negedge clk) beatSeen = beat;
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) if (beatSeen[i]) wordCnt[i] = wordCnt[i] + 16'd1;
        wdata = {16'd7 + wordCnt[2], 16'h2000 + wordCnt[1], 16'h1000 + wordCnt[0]};
    end

    // Monitor: memory model plus scoreboard compare on every cycle.
    always @(negedge clk) begin
        expEvent_t e;
        if (mem_we) mem[int'(mem_addr)] = mem_wdata;
        while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
            nChecks++;
            $display("FAIL missed event @cyc %0d: got nothing, required event at cyc %0d", cyc, expQ[0].cyc);
            void'(expQ.pop_front());
        end
        if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
            e = expQ.pop_front();
            check("event {gnt,beat,rvalid,done,we,addr,wdata}",
                  64'({gnt, beat, rvalid, done, mem_we, mem_addr, mem_wdata}),
                  64'({e.gnt, e.beat, e.rvalid, e.done, e.we, e.addr, e.wdata}));
        end else begin
            check("idle {gnt,beat,rvalid,done,we,addr}",
                  64'({gnt, beat, rvalid, done, mem_we, mem_addr}), 64'(0));
        end
    end

    task automatic pushBurst(input int r, input logic w, input logic [15:0] a,
                             input int n, input int t0, input bit full);
        expEvent_t  e;
        logic [2:0] oh;
        oh = 3'(1 << r);
        for (int k = 0; k < n; k++) begin
            e.cyc    = t0 + k;
            e.gnt    = oh;
            e.beat   = oh;
            e.rvalid = (k > 0 && !w) ? oh : 3'b000;
            e.done   = 3'b000;
            e.we     = w;
            e.addr   = 16'(a + k);
            e.wdata  = wordBase(r) + 16'(expCnt[r]);
            expCnt[r]++;
            expQ.push_back(e);
        end
        if (full) begin
            e.cyc    = t0 + n;
            e.gnt    = 3'b000;
            e.beat   = 3'b000;
            e.rvalid = (n > 0 && !w) ? oh : 3'b000;
            e.done   = oh;
            e.we     = 1'b0;
            e.addr   = 16'h0000;
            e.wdata  = 16'h0000;
            expQ.push_back(e);
        end
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] w,
                         input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                         input logic [15:0] l0, input logic [15:0] l1, input logic [15:0] l2);
        req  = r;
        we   = w;
        addr = {a2, a1, a0};
        len  = {l2, l1, l0};
    endtask

    function automatic logic [15:0] memRd(input int a);
        return mem.exists(a) ? mem[a] : 16'hxxxx;
    endfunction

    initial begin
        reset = 1'b0;
        req   = '0;
        we    = '0;
        addr  = '0;
        len   = '0;
        wdata = {16'd7, 16'h2000, 16'h1000};
        repeat (3) @(negedge clk);
        check("reset outputs", 64'({gnt, beat, rvalid, done, mem_we, mem_addr, mem_wdata}), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        // Read burst of 4 from 100 on the load path.
        drive(3'b001, 3'b000, 16'd100, 16'd0, 16'd0, 16'd4, 16'd0, 16'd0);
        pushBurst(0, 1'b0, 16'd100, 4, cyc + 1, 1'b1);
        @(negedge clk); req = '0;
        repeat (6) @(negedge clk);

        // Write burst of 3 to 500 on the pool path, data 7, 8, 9.
        drive(3'b100, 3'b100, 16'd0, 16'd0, 16'd500, 16'd0, 16'd0, 16'd3);
        pushBurst(2, 1'b1, 16'd500, 3, cyc + 1, 1'b1);
        @(negedge clk); req = '0;
        repeat (5) @(negedge clk);
        check("mem[500]", 64'(memRd(500)), 64'(16'd7));
        check("mem[501]", 64'(memRd(501)), 64'(16'd8));
        check("mem[502]", 64'(memRd(502)), 64'(16'd9));
        check("mem write count", 64'(mem.num()), 64'(3));

        // All three requesting single-word reads: grants 0, 1, 2, 0 three cycles apart.
        drive(3'b111, 3'b000, 16'd10, 16'd20, 16'd30, 16'd1, 16'd1, 16'd1);
        pushBurst(0, 1'b0, 16'd10, 1, cyc + 1, 1'b1);
        pushBurst(1, 1'b0, 16'd20, 1, cyc + 4, 1'b1);
        pushBurst(2, 1'b0, 16'd30, 1, cyc + 7, 1'b1);
        pushBurst(0, 1'b0, 16'd10, 1, cyc + 10, 1'b1);
        repeat (10) @(negedge clk);
        req = '0;
        repeat (4) @(negedge clk);

        // Address wraps past FFFF.
        drive(3'b010, 3'b000, 16'd0, 16'hFFFE, 16'd0, 16'd0, 16'd4, 16'd0);
        pushBurst(1, 1'b0, 16'hFFFE, 4, cyc + 1, 1'b1);
        @(negedge clk); req = '0;
        repeat (6) @(negedge clk);

        // Zero-length burst: done only, no beat.
        drive(3'b010, 3'b000, 16'd0, 16'h0040, 16'd0, 16'd0, 16'd0, 16'd0);
        pushBurst(1, 1'b0, 16'h0040, 0, cyc + 1, 1'b1);
        @(negedge clk); req = '0;
        repeat (3) @(negedge clk);

        // Reset during the 2nd beat of an 8-word write: burst abandoned, no done.
        drive(3'b010, 3'b010, 16'd0, 16'h0200, 16'd0, 16'd0, 16'd8, 16'd0);
        pushBurst(1, 1'b1, 16'h0200, 2, cyc + 1, 1'b0);
        @(negedge clk); req = '0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check("async reset mid-burst", 64'({gnt, beat, rvalid, done, mem_we, mem_addr, mem_wdata}), 64'(0));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Pointer restarts at 0: with 1 and 2 requesting, 1 wins first.
        drive(3'b110, 3'b000, 16'd0, 16'd40, 16'd50, 16'd0, 16'd1, 16'd1);
        pushBurst(1, 1'b0, 16'd40, 1, cyc + 1, 1'b1);
        pushBurst(2, 1'b0, 16'd50, 1, cyc + 4, 1'b1);
        repeat (4) @(negedge clk);
        req = '0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clk);
        check("scoreboard drained", 64'(expQ.size()), 64'(0));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
